// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller.
// Takes one miss request at a time and fetches the whole line over AHB-Lite as a
// single read-only wrapping burst that starts at the missed word. The missed word
// is forwarded as soon as it arrives. The full line is delivered one cycle after
// its last beat. An hresp ERROR abandons the burst and reports a single err pulse.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    // Miss interface
    input  logic                         miss_req,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         miss_ack,
    output logic                         busy,
    // Cache array interface
    output logic                         crit_valid,
    output logic [DATA_W-1:0]            crit_data,
    output logic                         line_valid,
    output logic [ADDR_W-1:0]            line_addr,
    output logic [LINE_WORDS*DATA_W-1:0] line_data,
    output logic                         err,
    // AHB-Lite master
    output logic [ADDR_W-1:0]            haddr,
    output logic [1:0]                   htrans,
    output logic [2:0]                   hburst,
    output logic                         hwrite,
    output logic [2:0]                   hsize,
    input  logic                         hready,
    input  logic [DATA_W-1:0]            hrdata,
    input  logic                         hresp
);

    localparam int OFF_W      = $clog2(LINE_WORDS);   // word-offset bits within a line
    localparam int BYTE_OFF_W = OFF_W + 2;            // byte-offset bits within a line
    localparam int CNT_W      = OFF_W + 1;            // beat counter must reach LINE_WORDS

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS*4 - 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_CODE = (LINE_WORDS == 16) ? 3'b110 :
                                         (LINE_WORDS == 8)  ? 3'b100 : 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,   // waiting for a miss
        S_ADDR,   // NONSEQ address phase of beat 0
        S_BEATS,  // address phase of beat k overlapping data phase of beat k-1
        S_ERR     // waiting out the second cycle of an error response
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;     // address beat in flight; data beat is beat_q-1
    logic [ADDR_W-1:0]  base_q;             // line base address
    logic [OFF_W-1:0]   start_q;            // critical word offset
    logic [DATA_W-1:0]  words_q [LINE_WORDS];

    logic               addr_en;
    logic [OFF_W-1:0]   addr_off;
    logic [OFF_W-1:0]   wr_off;
    logic               capture;
    logic               line_done;
    logic               err_set;

    assign hburst    = HBURST_CODE;
    assign hwrite    = 1'b0;
    assign hsize     = 3'b010;
    assign busy      = (state_q != S_IDLE);
    assign line_addr = base_q;

    // The word arriving in the current data phase belongs to the previous address beat.
    assign wr_off = start_q + beat_q[OFF_W-1:0] - OFF_W'(1);

    // Address shown on the bus; zero whenever no transfer is being requested.
    assign haddr = addr_en ? (base_q | ADDR_W'({addr_off, 2'b00})) : '0;

    // Next-state logic and the per-state bus/handshake controls.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        beat_d    = beat_q;
        miss_ack  = 1'b0;
        htrans    = HTRANS_IDLE;
        addr_en   = 1'b0;
        addr_off  = '0;
        capture   = 1'b0;
        line_done = 1'b0;
        err_set   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                miss_ack = miss_req;
                if (miss_req) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                htrans   = HTRANS_NONSEQ;
                addr_en  = 1'b1;
                addr_off = start_q;
                if (hready) begin
                    state_d = S_BEATS;
                    beat_d  = CNT_W'(1);
                end
            end

            S_BEATS: begin
                // Keep issuing SEQ addresses until all of them are out; the last data phase runs under IDLE.
                if (beat_q != LAST_BEAT) begin
                    htrans   = HTRANS_SEQ;
                    addr_en  = 1'b1;
                    addr_off = start_q + beat_q[OFF_W-1:0];
                end
                if (hresp) begin
                    // First cycle of an error response: drop the pending transfer next cycle.
                    state_d = S_ERR;
                end else if (hready) begin
                    capture = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        line_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end

            S_ERR: begin
                if (hready) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Latch line base and critical word offset when a miss is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q  <= '0;
            start_q <= '0;
        end else if (miss_ack) begin
            base_q  <= miss_addr & LINE_MASK;
            start_q <= miss_addr[BYTE_OFF_W-1:2];
        end
    end

    // Line buffer: each captured beat lands in its address-order slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the buffer is a handful of flops, not a RAM macro, so clearing it on reset is legal and cheap.
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (capture) begin
            words_q[wr_off] <= hrdata;
        end
    end

    // Registered pulses towards the cache: critical word, completed line, bus error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
            line_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            crit_valid <= capture && (beat_q == CNT_W'(1));
            if (capture && (beat_q == CNT_W'(1))) begin
                crit_data <= hrdata;
            end
            line_valid <= line_done;
            err        <= err_set;
        end
    end

    // Flatten the line buffer onto the line_data bus.
    always_comb begin
        line_data = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_data[i*DATA_W +: DATA_W] = words_q[i];
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Testbench for icache_refill_ctrl: AHB slave model with wait states and error
// responses, request driver, and a scoreboard monitor that checks bus transfers,
// critical word, line delivery and error pulses against a line-level model.
module tb_icache_refill_ctrl;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          miss_ack;
    logic          busy;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          line_valid;
    logic [31:0]   line_addr;
    logic [127:0]  line_data;
    logic          err;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hwrite;
    logic [2:0]    hsize;
    logic          hready;
    logic [31:0]   hrdata;
    logic          hresp;

    icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .rstn(rstn),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack), .busy(busy),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data), .err(err),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hwrite(hwrite), .hsize(hsize),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] trans; logic [31:0] addr; } xfer_t;
    typedef struct { logic [31:0] data; int cyc; } crit_t;
    typedef struct { logic [31:0] addr; logic [127:0] data; int cyc; } line_t;
    typedef struct { int err_beat; int wait_beat; int wait_cycles; bit rnd; } plan_t;

    xfer_t exp_x[$];
    crit_t exp_c[$];
    line_t exp_l[$];
    plan_t plan_q[$];
    int    err_exp = 0;

    int n_checks = 0;
    int n_errors = 0;
    int n_issued = 0;
    int n_acks   = 0;
    int cyc      = 0;
    bit rnd_mode = 1'b0;

    localparam plan_t PLAN_NONE = '{err_beat: -1, wait_beat: -1, wait_cycles: 0, rnd: 1'b0};

    // Memory contents the slave returns for any word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // AHB slave: tracks data phases, inserts planned wait states and two-cycle error responses.
    initial begin : slave
        bit          dp_valid  = 1'b0;
        logic [31:0] dp_addr   = '0;
        int          dp_beat   = 0;
        int          waits     = 0;
        int          err_stage = 0;
        plan_t       cur       = PLAN_NONE;
        bit          acc;
        bit          acc_ns;
        logic [31:0] acc_addr;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        forever begin
            @(negedge clk);
            acc      = rstn && hready && htrans[1];
            acc_ns   = (htrans == 2'b10);
            acc_addr = haddr;
            @(posedge clk);
            #1;
            if (!rstn) begin
                dp_valid = 1'b0;
                hready   = 1'b1;
                hresp    = 1'b0;
            end else begin
                if (hready) begin
                    dp_valid = acc;
                    if (acc) begin
                        dp_addr = acc_addr;
                        if (acc_ns) begin
                            cur     = (plan_q.size() > 0) ? plan_q.pop_front() : PLAN_NONE;
                            dp_beat = 0;
                        end else begin
                            dp_beat++;
                        end
                        if (dp_beat == cur.wait_beat) waits = cur.wait_cycles;
                        else if (cur.rnd && $urandom_range(0, 3) == 0) waits = $urandom_range(1, 2);
                        else waits = 0;
                        err_stage = (dp_beat == cur.err_beat) ? 1 : 0;
                    end
                end
                if (dp_valid) begin
                    if (waits > 0) begin
                        hready = 1'b0; hresp = 1'b0; waits--;
                    end else if (err_stage == 1) begin
                        hready = 1'b0; hresp = 1'b1; err_stage = 2;
                    end else if (err_stage == 2) begin
                        hready = 1'b1; hresp = 1'b1; err_stage = 0;
                    end else begin
                        hready = 1'b1; hresp = 1'b0;
                    end
                end else begin
                    hready = (rnd_mode && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                    hresp  = 1'b0;
                end
                hrdata = (dp_valid && hready && !hresp) ? mem_word(dp_addr) : $urandom();
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer or a result pulse.
    initial begin : monitor
        bit          prev_err   = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_addr  = '0;
        logic [1:0]  prev_trans = '0;
        xfer_t x;
        crit_t c;
        line_t l;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_err   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (miss_ack) n_acks++;
                if (prev_err) check("htrans_after_err", htrans, 2'b00);
                else if (prev_stall) check("addr_hold", {htrans, haddr}, {prev_trans, prev_addr});

                if (htrans != 2'b00 && hready) begin
                    if (exp_x.size() == 0) begin
                        check("xfer_unexpected", htrans, 2'b00);
                    end else begin
                        x = exp_x.pop_front();
                        check("xfer", {htrans, haddr}, {x.trans, x.addr});
                        check("xfer_ctrl", {hwrite, hsize, hburst}, {1'b0, 3'b010, 3'b010});
                    end
                end
                if (crit_valid) begin
                    if (exp_c.size() == 0) begin
                        check("crit_unexpected", crit_valid, 1'b0);
                    end else begin
                        c = exp_c.pop_front();
                        check("crit_data", crit_data, c.data);
                        if (c.cyc >= 0) check("crit_cycle", cyc, c.cyc);
                    end
                end
                if (line_valid) begin
                    if (exp_l.size() == 0) begin
                        check("line_unexpected", line_valid, 1'b0);
                    end else begin
                        l = exp_l.pop_front();
                        check("line_addr", line_addr, l.addr);
                        check("line_data", line_data, l.data);
                        if (l.cyc >= 0) check("line_cycle", cyc, l.cyc);
                    end
                end
                if (err) begin
                    if (err_exp == 0) check("err_unexpected", err, 1'b0);
                    else err_exp--;
                end
                prev_err   = hresp && !hready;
                prev_stall = (htrans != 2'b00) && !hready && !hresp;
                prev_addr  = haddr;
                prev_trans = htrans;
            end
        end
    end

    // Raise a request, wait for its acceptance, then record what the refill must produce.
    task automatic issue(input logic [31:0] a, input plan_t p, input bit chk_lat, output int ack_cyc);
        bit          got = 1'b0;
        logic [31:0] base;
        int          s;
        int          n_acc;
        int          extra;
        crit_t       c;
        line_t       l;
        @(posedge clk);
        #1;
        miss_req  = 1'b1;
        miss_addr = a;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (miss_ack) got = 1'b1;
        end
        check("ack_seen", got, 1'b1);
        ack_cyc = cyc;
        if (!got) return;
        n_issued++;
        plan_q.push_back(p);
        base  = a & ~32'hF;
        s     = int'((a >> 2) % LW);
        n_acc = (p.err_beat < 0) ? LW : p.err_beat + 1;
        for (int k = 0; k < n_acc; k++) begin
            exp_x.push_back('{trans: (k == 0) ? 2'b10 : 2'b11,
                              addr:  base + 32'(((s + k) % LW) * 4)});
        end
        extra = (p.wait_beat >= 0 && p.wait_beat < LW) ? p.wait_cycles : 0;
        if (p.err_beat != 0) begin
            c.data = mem_word(base + 32'(s * 4));
            c.cyc  = chk_lat ? ack_cyc + 3 + ((p.wait_beat == 0) ? p.wait_cycles : 0) : -1;
            exp_c.push_back(c);
        end
        if (p.err_beat < 0) begin
            l.addr = base;
            for (int i = 0; i < LW; i++) l.data[i*32 +: 32] = mem_word(base + 32'(i * 4));
            l.cyc = chk_lat ? ack_cyc + 2 + LW + extra : -1;
            exp_l.push_back(l);
        end else begin
            err_exp++;
        end
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        miss_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_x.size() == 0 && exp_c.size() == 0 && exp_l.size() == 0 && err_exp == 0)
                done = 1'b1;
        end
        check("idle_reached", done, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus"}, {htrans, haddr, hwrite, hsize, hburst}, {2'b00, 32'h0, 1'b0, 3'b010, 3'b010});
        check({tag, "_flags"}, {busy, miss_ack, crit_valid, line_valid, err}, 5'b0);
        check({tag, "_data"}, {crit_data, line_addr}, 64'h0);
        check({tag, "_line"}, line_data, 128'h0);
    endtask

    initial begin : stim
        int    a0;
        int    a1;
        plan_t p;
        rstn      = 1'b0;
        miss_req  = 1'b0;
        miss_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        rstn = 1'b1;

        // Plain refill, zero wait states.
        issue(32'h0000_1008, PLAN_NONE, 1'b1, a0);
        drop_req();
        wait_idle();

        // Two wait states on the beat 1 data phase.
        p = PLAN_NONE; p.wait_beat = 1; p.wait_cycles = 2;
        issue(32'h0000_1008, p, 1'b1, a0);
        drop_req();
        wait_idle();

        // Unaligned byte address: treated as its word.
        issue(32'h0000_100F, PLAN_NONE, 1'b1, a0);
        drop_req();
        wait_idle();

        // Error response on beat 2, then a normal refill.
        p = PLAN_NONE; p.err_beat = 2;
        issue(32'h0000_1000, p, 1'b0, a0);
        drop_req();
        wait_idle();
        issue(32'h0000_2000, PLAN_NONE, 1'b1, a0);
        drop_req();
        wait_idle();

        // Asynchronous reset mid-burst, then a clean refill.
        issue(32'h0000_5010, PLAN_NONE, 1'b0, a0);
        drop_req();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_x.delete();
        exp_c.delete();
        exp_l.delete();
        plan_q.delete();
        err_exp = 0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        issue(32'h0000_3004, PLAN_NONE, 1'b1, a0);
        drop_req();
        wait_idle();

        // Request held across line_valid with a new address: back-to-back refills.
        issue(32'h0000_4004, PLAN_NONE, 1'b1, a0);
        issue(32'h0000_4038, PLAN_NONE, 1'b1, a1);
        check("b2b_ack_cycle", a1, a0 + 2 + LW);
        drop_req();
        wait_idle();

        // Randomized refills with wait states, idle stalls, errors and held requests.
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            p = PLAN_NONE;
            p.rnd = 1'b1;
            if ($urandom_range(0, 4) == 0) p.err_beat = $urandom_range(0, LW - 1);
            issue($urandom(), p, 1'b0, a0);
            if ($urandom_range(0, 3) != 0) begin
                drop_req();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        drop_req();
        wait_idle();
        rnd_mode = 1'b0;

        check("pending_xfer", exp_x.size(), 0);
        check("pending_crit", exp_c.size(), 0);
        check("pending_line", exp_l.size(), 0);
        check("pending_err", err_exp, 0);
        check("ack_count", n_acks, n_issued);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
